// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle for the branch predictor:
// lookup request, registered prediction, and resolved-branch training.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            lookup_valid_i;
  logic [XLEN-1:0] lookup_pc_i;
  logic            pred_valid_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            upd_valid_i;
  logic            upd_is_branch_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;

  modport master (
    output lookup_valid_i, lookup_pc_i,
    output upd_valid_i, upd_is_branch_i,
    output upd_pc_i, upd_taken_i, upd_target_i,
    input  pred_valid_o, pred_taken_o, pred_target_o
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i,
    input  upd_valid_i, upd_is_branch_i,
    input  upd_pc_i, upd_taken_i, upd_target_i,
    output pred_valid_o, pred_taken_o, pred_target_o
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit counter table + tagged BTB, registered prediction, read-first.
// Define BP_GSHARE_EN to xor a global history into the counter index.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LO   = IDX_BITS + 2;
  localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  logic [1:0]      ctr    [ENTRIES];
  logic [ENTRIES-1:0] btb_v;
  tag_t            btb_tag [ENTRIES];
  logic [XLEN-1:0] btb_tgt [ENTRIES];

  idx_t l_idx;
  idx_t l_cidx;
  tag_t l_tag;
  logic l_hit;
  logic l_taken;
  idx_t u_idx;
  idx_t u_cidx;
  tag_t u_tag;
  logic u_hit;
  logic u_en;
  logic unused;

  assign unused = ^{bp.lookup_pc_i[XLEN-1:TAG_HI+1],
                    bp.lookup_pc_i[1:0],
                    bp.upd_pc_i[XLEN-1:TAG_HI+1],
                    bp.upd_pc_i[1:0]};

  assign l_idx = bp.lookup_pc_i[TAG_LO-1:2];
  assign l_tag = bp.lookup_pc_i[TAG_HI:TAG_LO];
  assign u_idx = bp.upd_pc_i[TAG_LO-1:2];
  assign u_tag = bp.upd_pc_i[TAG_HI:TAG_LO];

`ifdef BP_GSHARE_EN
  idx_t ghr;

  // Lookup and update both see pre-shift history.
  assign l_cidx = l_idx ^ ghr;
  assign u_cidx = u_idx ^ ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (u_en) begin
      ghr <= {ghr[IDX_BITS-2:0], bp.upd_taken_i};
    end
  end
`else
  assign l_cidx = l_idx;
  assign u_cidx = u_idx;
`endif

  assign l_hit   = btb_v[l_idx] && (btb_tag[l_idx] == l_tag);
  assign l_taken = l_hit && ctr[l_cidx][1];
  assign u_hit   = btb_v[u_idx] && (btb_tag[u_idx] == u_tag);
  assign u_en    = bp.upd_valid_i && bp.upd_is_branch_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp.pred_valid_o  <= 1'b0;
      bp.pred_taken_o  <= 1'b0;
      bp.pred_target_o <= '0;
    end else begin
      bp.pred_valid_o  <= bp.lookup_valid_i;
      bp.pred_taken_o  <= bp.lookup_valid_i && l_taken;
      bp.pred_target_o <= (bp.lookup_valid_i && l_taken)
                        ? btb_tgt[l_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_v <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i]     <= 2'b01;
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
      end
    end else if (u_en) begin
      unique case (1'b1)
        u_hit && bp.upd_taken_i: begin
          if (ctr[u_cidx] != 2'b11)
            ctr[u_cidx] <= ctr[u_cidx] + 2'd1;
          btb_tgt[u_idx] <= bp.upd_target_i;
        end
        u_hit && !bp.upd_taken_i: begin
          if (ctr[u_cidx] != 2'b00)
            ctr[u_cidx] <= ctr[u_cidx] - 2'd1;
        end
        !u_hit && bp.upd_taken_i: begin
          btb_v[u_idx]   <= 1'b1;
          btb_tag[u_idx] <= u_tag;
          btb_tgt[u_idx] <= bp.upd_target_i;
          ctr[u_cidx]    <= 2'b10;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a table-level reference model
// checked every cycle, plus literal expectations from the test plan.
`timescale 1ns/100ps
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  branch_predictor_if #(.XLEN(32)) bp ();

  branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_BITS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bp)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, one slot per word-address mod 64.
  int          m_cnt [64];
  bit          m_val [64];
  int unsigned m_tag [64];
  int unsigned m_tgt [64];
  int unsigned m_hist;
  bit          e_valid;
  bit          e_taken;
  int unsigned e_target;

  function automatic int slot(input int unsigned pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int unsigned tagof(input int unsigned pc);
    return (pc >> 8) % 256;
  endfunction

  function automatic int cslot(input int unsigned pc, input int unsigned h);
`ifdef BP_GSHARE_EN
    return int'((((pc >> 2) % 64) ^ h) % 64);
`else
    return slot(pc + 0 * h);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int s;
    int c;
    bit hit;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        m_cnt[i] = 1;
        m_val[i] = 0;
        m_tag[i] = 0;
        m_tgt[i] = 0;
      end
      m_hist   = 0;
      e_valid  = 0;
      e_taken  = 0;
      e_target = 0;
    end else begin
      s   = slot(bp.lookup_pc_i);
      c   = cslot(bp.lookup_pc_i, m_hist);
      hit = m_val[s] && m_tag[s] == tagof(bp.lookup_pc_i);
      e_valid  = bp.lookup_valid_i;
      e_taken  = bp.lookup_valid_i && hit && m_cnt[c] >= 2;
      e_target = e_taken ? m_tgt[s] : 0;
      if (bp.upd_valid_i && bp.upd_is_branch_i) begin
        s   = slot(bp.upd_pc_i);
        c   = cslot(bp.upd_pc_i, m_hist);
        hit = m_val[s] && m_tag[s] == tagof(bp.upd_pc_i);
        if (hit && bp.upd_taken_i) begin
          m_cnt[c] = (m_cnt[c] + 1 > 3) ? 3 : m_cnt[c] + 1;
          m_tgt[s] = bp.upd_target_i;
        end else if (hit) begin
          m_cnt[c] = (m_cnt[c] - 1 < 0) ? 0 : m_cnt[c] - 1;
        end else if (bp.upd_taken_i) begin
          m_val[s] = 1;
          m_tag[s] = tagof(bp.upd_pc_i);
          m_tgt[s] = bp.upd_target_i;
          m_cnt[c] = 2;
        end
        m_hist = ((m_hist << 1) | 32'(bp.upd_taken_i)) % 64;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bp.pred_valid_o === e_valid && bp.pred_taken_o === e_taken &&
          bp.pred_target_o === e_target)
        passes++;
      else
        $display("FAIL model t=%0t: got v=%b t=%b tgt=%h want v=%b t=%b tgt=%h",
                 $time, bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o,
                 e_valid, e_taken, e_target);
    end
  end

  task automatic lit(input string name, input bit v, input bit t,
                     input logic [31:0] tgt);
    checks++;
    if (bp.pred_valid_o === v && bp.pred_taken_o === t &&
        bp.pred_target_o === tgt)
      passes++;
    else
      $display("FAIL %s: got v=%b t=%b tgt=%h want v=%b t=%b tgt=%h",
               name, bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o,
               v, t, tgt);
  endtask

  task automatic drive(input bit lv, input logic [31:0] lpc,
                       input bit uv, input bit ub, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt);
    bp.lookup_valid_i  = lv;
    bp.lookup_pc_i     = lpc;
    bp.upd_valid_i     = uv;
    bp.upd_is_branch_i = ub;
    bp.upd_pc_i        = upc;
    bp.upd_taken_i     = ut;
    bp.upd_target_i    = utgt;
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc);
    drive(1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t,
                     input logic [31:0] tgt);
    drive(0, 0, 1, 1, pc, t, tgt);
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h40; pcs[1] = 32'h1040;
    pcs[2] = 32'h80; pcs[3] = 32'h44;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    lit("reset_state", 0, 0, 0);
    rst_n = 1'b1;

    look(32'h40);
    lit("cold_lookup", 1, 0, 0);
    upd(32'h40, 1, 32'h100);
    look(32'h40);
    lit("alloc_taken", 1, 1, 32'h100);

    repeat (3) upd(32'h40, 0, 32'h0);
    look(32'h40);
    lit("sat_low", 1, 0, 0);
    repeat (2) upd(32'h40, 1, 32'h100);
    look(32'h40);
    lit("climb_back", 1, 1, 32'h100);
    repeat (4) upd(32'h40, 1, 32'h100);
    upd(32'h40, 0, 32'h0);
    look(32'h40);
    lit("sat_high_1dec", 1, 1, 32'h100);
    upd(32'h40, 0, 32'h0);
    look(32'h40);
    lit("sat_high_2dec", 1, 0, 0);

    look(32'h1040);
    lit("alias_miss", 1, 0, 0);
    upd(32'h1040, 1, 32'h200);
    look(32'h40);
    lit("alias_evicted", 1, 0, 0);
    look(32'h1040);
    lit("alias_hit", 1, 1, 32'h200);

    drive(1, 32'h80, 1, 1, 32'h80, 1, 32'h300);
    lit("read_first", 1, 0, 0);
    look(32'h80);
    lit("after_same_cycle", 1, 1, 32'h300);

    drive(0, 0, 1, 0, 32'hC0, 1, 32'h400);
    lit("idle", 0, 0, 0);
    look(32'hC0);
    lit("non_branch_ignored", 1, 0, 0);

    look(32'h80);
    #2 rst_n = 1'b0;
    #0.5 lit("async_reset", 0, 0, 0);
    #0.5 rst_n = 1'b1;
    @(negedge clk);
    look(32'h40);
    lit("post_rst_40", 1, 0, 0);
    look(32'h1040);
    lit("post_rst_1040", 1, 0, 0);
    look(32'h80);
    lit("post_rst_80", 1, 0, 0);

`ifdef BP_GSHARE_EN
    upd(32'h40, 1, 32'h100);
    look(32'h40);
    lit("gshare_idx", 1, 0, 0);
`endif

    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 1), pcs[$urandom_range(0, 3)],
            $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            pcs[$urandom_range(0, 3)], $urandom_range(0, 1),
            32'($urandom_range(1, 15)) << 4);

    drive(0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the fetch stage of the next-generation pipelined RISC-V core.
- Replaces the current resolve-then-redirect scheme, where a branch outcome (branch & zero) is registered and then selects between PC+4 and the branch target.
- Direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB).
- Returns a registered taken/target prediction one cycle after lookup; trained by the execute stage when a branch resolves.

Parameters:
- XLEN, 32, address/target width.
- ENTRIES, 64, table depth; power of 2, minimum 4. IDX_BITS = log2(ENTRIES).
- TAG_BITS, 8, BTB tag width; IDX_BITS+TAG_BITS+2 <= XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_valid_i  in  1  fetch requests a prediction this cycle.
- lookup_pc_i  in  XLEN  PC being fetched.
- pred_valid_o  out  1  prediction valid; registered copy of lookup_valid_i.
- pred_taken_o  out  1  predict taken.
- pred_target_o  out  XLEN  predicted target; 0 when pred_taken_o=0.
- upd_valid_i  in  1  a resolved instruction is reported this cycle.
- upd_is_branch_i  in  1  the reported instruction is a conditional branch.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_taken_i  in  1  actual outcome.
- upd_target_i  in  XLEN  actual target (PC + imm).

Behaviour:
- Clock and reset: already decided — one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Index and tag:
  - idx = pc[IDX_BITS+1:2].
  - tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Reset values:
  - All counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0; all tags and targets = 0.
  - pred_valid_o = 0, pred_taken_o = 0, pred_target_o = 0.
  - Reset asserted mid-operation clears everything immediately, independent of clk.
- Lookup, latency 1:
  - At the edge after lookup_valid_i=1:
    - hit = btb_valid[idx] && btb_tag[idx]==tag.
    - pred_taken_o = hit && ctr[idx][1].
    - pred_target_o = pred_taken_o ? btb_target[idx] : 0.
  - lookup_valid_i=0: pred_valid_o=0, pred_taken_o=0, pred_target_o=0 on the next edge.
- Update (upd_valid_i=1 && upd_is_branch_i=1), applied at the edge:
  - BTB hit, taken: ctr saturating increment (11 stays 11); btb_target <= upd_target_i.
  - BTB hit, not taken: ctr saturating decrement (00 stays 00).
  - BTB miss, taken: allocate/replace entry: valid=1, tag, target, ctr=2'b10.
  - BTB miss, not taken: no state change.
- upd_valid_i=1 with upd_is_branch_i=0: no state change.
- Lookup and update in the same cycle:
  - Read-first: the prediction reflects pre-update state, including when both address the same index.
  - The update is never dropped.
- Lookup and update are independent; no backpressure, one of each per cycle.
- The predictor never raises a mispredict. The pipeline compares pred_taken_o/pred_target_o against the resolved outcome.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Adds an IDX_BITS-wide global history register (ghr), reset to 0.
  - Counter index = pc[IDX_BITS+1:2] ^ ghr, for both lookup and update. BTB still uses the plain pc index and tag.
  - On each branch update, ghr <= {ghr[IDX_BITS-2:0], upd_taken_i}.
  - Lookup uses the ghr value before the same-cycle shift.
  - The hit/tag check still gates pred_taken_o.
- Undefined: no ghr; behaviour exactly as above.

Test Plan (ENTRIES=64, TAG_BITS=8, macro undefined unless stated):
- Reset, then lookup 0x40 -> next cycle pred_valid_o=1, pred_taken_o=0, pred_target_o=0.
- Update 0x40 taken, target 0x100; lookup 0x40 -> pred_taken_o=1, pred_target_o=0x100 (ctr=10).
- Counter saturation from ctr=10 at 0x40:
  - Three not-taken updates (ctr 10->01->00->00) -> lookup predicts 0.
  - Two taken updates (00->01->10) -> predicts 1, target 0x100.
  - Four more taken updates -> ctr stays 11.
- Alias 0x1040 (same idx, tag 0x10):
  - Lookup -> pred_taken_o=0.
  - Update taken, target 0x200 -> entry replaced.
  - Lookup 0x40 -> 0; lookup 0x1040 -> 1, target 0x200.
- Same-cycle lookup and update at fresh entry 0x80 (taken, target 0x300) -> that cycle's prediction pred_taken_o=0; next lookup -> 1.
- rst_n low for 1 ns mid-stream after the above, no clk edge -> outputs 0 immediately; all prior entries predict 0.
- BP_GSHARE_EN defined:
  - Taken update at 0x40 -> ghr=000001.
  - Lookup 0x40 indexes counter 0x11, still 01 -> pred_taken_o=0.
